// File: rtl/vit_pkg.sv
// =============================================================================
// vit_pkg - shared types and helpers for the Viterbi trellis memory sequencer
// Rev 1.0
// =============================================================================
`default_nettype none

package vit_pkg;

   localparam int ADDR_W_DEFAULT = 10;
   localparam int SEL_W_DEFAULT  = 8;

   typedef enum logic [1:0] {
      BANK_A = 2'd0,
      BANK_B = 2'd1,
      BANK_C = 2'd2,
      BANK_D = 2'd3
   } bank_t;

   typedef enum logic [1:0] {
      ROLE_WR   = 2'd0,
      ROLE_RD   = 2'd1,
      ROLE_IDLE = 2'd2
   } role_t;

   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t FILL = 2'd1;
   localparam state_t RUN  = 2'd2;

   // Offset is (bank index - current write bank) mod 4
   function automatic role_t bank_role(input logic [1:0] offset);
      case (offset)
         2'd0:    return ROLE_WR;
         2'd2:    return ROLE_IDLE;
         default: return ROLE_RD;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/trellis_tbu_route.sv
// =============================================================================
// trellis_tbu_route - registered bank-to-traceback data mux and selection bits
// Rev 1.0
// =============================================================================
`default_nettype none

module trellis_tbu_route
   import vit_pkg::*;
#(
   parameter int SEL_W = SEL_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  bank_t            bank_d2,
   input  logic [SEL_W-1:0] dout_a,
   input  logic [SEL_W-1:0] dout_b,
   input  logic [SEL_W-1:0] dout_c,
   input  logic [SEL_W-1:0] dout_d,
   output logic [SEL_W-1:0] tbu0_d0,
   output logic [SEL_W-1:0] tbu0_d1,
   output logic             tbu0_sel,
   output logic [SEL_W-1:0] tbu1_d0,
   output logic [SEL_W-1:0] tbu1_d1,
   output logic             tbu1_sel
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tbu0_d0  <= '0;
         tbu0_d1  <= '0;
         tbu0_sel <= 1'b0;
         tbu1_d0  <= '0;
         tbu1_d1  <= '0;
         tbu1_sel <= 1'b0;
      end else begin
         case (bank_d2)
            BANK_A: begin
               tbu0_d0 <= dout_d; tbu0_d1 <= dout_c; tbu0_sel <= 1'b0;
               tbu1_d0 <= dout_c; tbu1_d1 <= dout_b; tbu1_sel <= 1'b1;
            end
            BANK_B: begin
               tbu0_d0 <= dout_d; tbu0_d1 <= dout_c; tbu0_sel <= 1'b1;
               tbu1_d0 <= dout_a; tbu1_d1 <= dout_d; tbu1_sel <= 1'b0;
            end
            BANK_C: begin
               tbu0_d0 <= dout_b; tbu0_d1 <= dout_a; tbu0_sel <= 1'b0;
               tbu1_d0 <= dout_a; tbu1_d1 <= dout_d; tbu1_sel <= 1'b1;
            end
            default: begin
               tbu0_d0 <= dout_b; tbu0_d1 <= dout_a; tbu0_sel <= 1'b1;
               tbu1_d0 <= dout_c; tbu1_d1 <= dout_b; tbu1_sel <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/trellis_mem_ctrl.sv
// =============================================================================
// trellis_mem_ctrl - four-bank survivor memory sequencer and traceback feeder
// Rev 1.0
// =============================================================================
`default_nettype none

module trellis_mem_ctrl
   import vit_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int SEL_W  = SEL_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [SEL_W-1:0]  sel_in,
   output logic [3:0]        mem_wr,
   output logic [ADDR_W-1:0] mem_addr_a,
   output logic [ADDR_W-1:0] mem_addr_b,
   output logic [ADDR_W-1:0] mem_addr_c,
   output logic [ADDR_W-1:0] mem_addr_d,
   output logic [SEL_W-1:0]  mem_din,
   input  logic [SEL_W-1:0]  mem_dout_a,
   input  logic [SEL_W-1:0]  mem_dout_b,
   input  logic [SEL_W-1:0]  mem_dout_c,
   input  logic [SEL_W-1:0]  mem_dout_d,
   output logic              tbu0_en,
   output logic              tbu1_en,
   output logic              tbu0_sel,
   output logic              tbu1_sel,
   output logic [SEL_W-1:0]  tbu0_d0,
   output logic [SEL_W-1:0]  tbu0_d1,
   output logic [SEL_W-1:0]  tbu1_d0,
   output logic [SEL_W-1:0]  tbu1_d1,
   output logic              running
);

   localparam logic [ADDR_W-1:0] c_last = {ADDR_W{1'b1}};

   state_t            r_state;
   logic [ADDR_W-1:0] r_wr_cnt;
   logic [ADDR_W-1:0] r_rd_cnt;
   bank_t             r_bank;
   bank_t             r_bank_d1;
   bank_t             r_bank_d2;

   logic [3:0]        w_wr;
   logic [ADDR_W-1:0] w_addr [4];
   logic              w_tbu0_set;
   logic              w_tbu1_set;

   // bank_d2 lines up with read data: one cycle for the address register, one for the RAM
   assign w_tbu0_set = (r_bank_d2 == BANK_C);
   assign w_tbu1_set = (r_bank_d2 == BANK_D);
   assign running    = (r_state == RUN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else if (!enable) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE:    r_state <= FILL;
            FILL:    if (w_tbu0_set) r_state <= RUN;
            RUN:     r_state <= RUN;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_cnt  <= '0;
         r_rd_cnt  <= c_last;
         r_bank    <= BANK_A;
         r_bank_d1 <= BANK_A;
         r_bank_d2 <= BANK_A;
         tbu0_en   <= 1'b0;
         tbu1_en   <= 1'b0;
      end else if (!enable) begin
         r_wr_cnt  <= '0;
         r_rd_cnt  <= c_last;
         r_bank    <= BANK_A;
         r_bank_d1 <= BANK_A;
         r_bank_d2 <= BANK_A;
         tbu0_en   <= 1'b0;
         tbu1_en   <= 1'b0;
      end else begin
         r_wr_cnt  <= r_wr_cnt + 1'b1;
         r_rd_cnt  <= r_rd_cnt - 1'b1;
         if (r_wr_cnt == c_last) r_bank <= bank_t'(r_bank + 2'd1);
         r_bank_d1 <= r_bank;
         r_bank_d2 <= r_bank_d1;
         if (w_tbu0_set) tbu0_en <= 1'b1;
         if (w_tbu1_set) tbu1_en <= 1'b1;
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_bank
      localparam logic [1:0] c_idx = 2'(i);
      role_t w_role;
      assign w_role    = bank_role(2'(c_idx - r_bank));
      assign w_wr[i]   = (w_role == ROLE_WR);
      assign w_addr[i] = (w_role == ROLE_WR) ? r_wr_cnt :
                         (w_role == ROLE_RD) ? r_rd_cnt : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_wr     <= '0;
         mem_addr_a <= '0;
         mem_addr_b <= '0;
         mem_addr_c <= '0;
         mem_addr_d <= '0;
         mem_din    <= '0;
      end else if (!enable) begin
         mem_wr     <= '0;
         mem_addr_a <= '0;
         mem_addr_b <= '0;
         mem_addr_c <= '0;
         mem_addr_d <= '0;
         mem_din    <= '0;
      end else begin
         mem_wr     <= w_wr;
         mem_addr_a <= w_addr[0];
         mem_addr_b <= w_addr[1];
         mem_addr_c <= w_addr[2];
         mem_addr_d <= w_addr[3];
         mem_din    <= sel_in;
      end
   end

   trellis_tbu_route #(
      .SEL_W (SEL_W)
   ) u_tbu_route (
      .clk      (clk),
      .rst      (rst),
      .bank_d2  (r_bank_d2),
      .dout_a   (mem_dout_a),
      .dout_b   (mem_dout_b),
      .dout_c   (mem_dout_c),
      .dout_d   (mem_dout_d),
      .tbu0_d0  (tbu0_d0),
      .tbu0_d1  (tbu0_d1),
      .tbu0_sel (tbu0_sel),
      .tbu1_d0  (tbu1_d0),
      .tbu1_d1  (tbu1_d1),
      .tbu1_sel (tbu1_sel)
   );

endmodule

`default_nettype wire

// File: tb/tb_trellis_mem_ctrl.sv
// =============================================================================
// tb_trellis_mem_ctrl - directed self-checking bench for trellis_mem_ctrl
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_trellis_mem_ctrl;

   localparam int ADDR_W = 3;
   localparam int SEL_W  = 8;
   localparam int DEPTH  = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             enable = 1'b0;
   logic [SEL_W-1:0] sel_in = '0;
   logic [3:0]       mem_wr;
   logic [ADDR_W-1:0] mem_addr_a, mem_addr_b, mem_addr_c, mem_addr_d;
   logic [SEL_W-1:0] mem_din;
   logic [SEL_W-1:0] mem_dout_a = 8'h11;
   logic [SEL_W-1:0] mem_dout_b = 8'h22;
   logic [SEL_W-1:0] mem_dout_c = 8'h33;
   logic [SEL_W-1:0] mem_dout_d = 8'h44;
   logic             tbu0_en, tbu1_en, tbu0_sel, tbu1_sel, running;
   logic [SEL_W-1:0] tbu0_d0, tbu0_d1, tbu1_d0, tbu1_d1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   trellis_mem_ctrl #(
      .ADDR_W (ADDR_W),
      .SEL_W  (SEL_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .sel_in     (sel_in),
      .mem_wr     (mem_wr),
      .mem_addr_a (mem_addr_a),
      .mem_addr_b (mem_addr_b),
      .mem_addr_c (mem_addr_c),
      .mem_addr_d (mem_addr_d),
      .mem_din    (mem_din),
      .mem_dout_a (mem_dout_a),
      .mem_dout_b (mem_dout_b),
      .mem_dout_c (mem_dout_c),
      .mem_dout_d (mem_dout_d),
      .tbu0_en    (tbu0_en),
      .tbu1_en    (tbu1_en),
      .tbu0_sel   (tbu0_sel),
      .tbu1_sel   (tbu1_sel),
      .tbu0_d0    (tbu0_d0),
      .tbu0_d1    (tbu0_d1),
      .tbu1_d0    (tbu1_d0),
      .tbu1_d1    (tbu1_d1),
      .running    (running)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Everything that an enable drop or a reset must zero
   task automatic check_clear(input string tag, input bit with_tbu_data);
      check({tag, "_mem_wr"}, 32'(mem_wr), 32'h0);
      check({tag, "_addr_a"}, 32'(mem_addr_a), 32'h0);
      check({tag, "_addr_b"}, 32'(mem_addr_b), 32'h0);
      check({tag, "_addr_c"}, 32'(mem_addr_c), 32'h0);
      check({tag, "_addr_d"}, 32'(mem_addr_d), 32'h0);
      check({tag, "_din"}, 32'(mem_din), 32'h0);
      check({tag, "_tbu0_en"}, 32'(tbu0_en), 32'h0);
      check({tag, "_tbu1_en"}, 32'(tbu1_en), 32'h0);
      check({tag, "_running"}, 32'(running), 32'h0);
      if (with_tbu_data) begin
         check({tag, "_tbu0_sel"}, 32'(tbu0_sel), 32'h0);
         check({tag, "_tbu1_sel"}, 32'(tbu1_sel), 32'h0);
         check({tag, "_tbu0_d0"}, 32'(tbu0_d0), 32'h0);
         check({tag, "_tbu0_d1"}, 32'(tbu0_d1), 32'h0);
         check({tag, "_tbu1_d0"}, 32'(tbu1_d0), 32'h0);
         check({tag, "_tbu1_d1"}, 32'(tbu1_d1), 32'h0);
      end
   endtask

   // Expected outputs just after enabled edge e (e=1 is the first enabled edge);
   // sel_in before edge e was e-1, and the douts are held at 11/22/33/44.
   task automatic check_cycle(input string ph, input int e);
      int w, bw, bd2, off;
      logic [ADDR_W-1:0] got_addr [4];
      logic [ADDR_W-1:0] exp_addr;
      logic [7:0] e00, e01, e10, e11;
      logic s0, s1;
      string t;
      w   = e - 1;
      bw  = (w / DEPTH) % 4;
      bd2 = (e >= 3) ? ((e - 3) / DEPTH) % 4 : 0;
      t   = $sformatf("%s_e%0d", ph, e);
      got_addr[0] = mem_addr_a;
      got_addr[1] = mem_addr_b;
      got_addr[2] = mem_addr_c;
      got_addr[3] = mem_addr_d;
      check({t, "_mem_wr"}, 32'(mem_wr), 32'(4'b0001 << bw));
      check({t, "_onehot"}, 32'($onehot(mem_wr)), 32'h1);
      check({t, "_din"}, 32'(mem_din), 32'(w[7:0]));
      for (int j = 0; j < 4; j++) begin
         off = (j - bw + 4) % 4;
         if (off == 0)      exp_addr = ADDR_W'(w % DEPTH);
         else if (off == 2) exp_addr = '0;
         else               exp_addr = ADDR_W'(DEPTH - 1 - (w % DEPTH));
         check($sformatf("%s_addr%0d", t, j), 32'(got_addr[j]), 32'(exp_addr));
      end
      check({t, "_tbu0_en"}, 32'(tbu0_en), 32'(e >= 2 * DEPTH + 3));
      check({t, "_tbu1_en"}, 32'(tbu1_en), 32'(e >= 3 * DEPTH + 3));
      check({t, "_running"}, 32'(running), 32'(e >= 2 * DEPTH + 3));
      case (bd2)
         0:       begin e00 = 8'h44; e01 = 8'h33; s0 = 1'b0; e10 = 8'h33; e11 = 8'h22; s1 = 1'b1; end
         1:       begin e00 = 8'h44; e01 = 8'h33; s0 = 1'b1; e10 = 8'h11; e11 = 8'h44; s1 = 1'b0; end
         2:       begin e00 = 8'h22; e01 = 8'h11; s0 = 1'b0; e10 = 8'h11; e11 = 8'h44; s1 = 1'b1; end
         default: begin e00 = 8'h22; e01 = 8'h11; s0 = 1'b1; e10 = 8'h33; e11 = 8'h22; s1 = 1'b0; end
      endcase
      check({t, "_tbu0_d0"}, 32'(tbu0_d0), 32'(e00));
      check({t, "_tbu0_d1"}, 32'(tbu0_d1), 32'(e01));
      check({t, "_tbu0_sel"}, 32'(tbu0_sel), 32'(s0));
      check({t, "_tbu1_d0"}, 32'(tbu1_d0), 32'(e10));
      check({t, "_tbu1_d1"}, 32'(tbu1_d1), 32'(e11));
      check({t, "_tbu1_sel"}, 32'(tbu1_sel), 32'(s1));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_clear("reset", 1'b1);

      // Run into bank B, then pull rst mid-cycle 13
      rst    = 1'b1;
      enable = 1'b1;
      sel_in = '0;
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk);
         #1;
         check_cycle("pre", e);
         sel_in = 8'(e);
      end
      #2;
      rst = 1'b0;
      #1;
      check_clear("async_rst", 1'b1);
      @(posedge clk);
      #1;
      check_clear("rst_held", 1'b1);

      // Release with enable high: full fill through tbu0/tbu1 enable and bank D
      rst    = 1'b1;
      sel_in = '0;
      for (int e = 1; e <= 29; e++) begin
         @(posedge clk);
         #1;
         check_cycle("run", e);
         sel_in = 8'(e);
      end

      // One-cycle enable drop at cycle 30
      enable = 1'b0;
      @(posedge clk);
      #1;
      check_clear("en_drop", 1'b0);
      enable = 1'b1;
      sel_in = '0;
      for (int e = 1; e <= 28; e++) begin
         @(posedge clk);
         #1;
         check_cycle("reen", e);
         sel_in = 8'(e);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
